// File: rtl/skinny_mask_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | skinny_mask_pkg : shared constants and FSM encoding for the sequencer    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package skinny_mask_pkg;

  localparam int NIBBLES = 16;
  localparam int RND_W   = 24;
  localparam int STATE_W = 4 * NIBBLES;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam int CNT_W   = $clog2(NIBBLES + 1);

  localparam logic [CNT_W-1:0] NIB_CNT = CNT_W'(NIBBLES);

  localparam int R_LSB    = 0;
  localparam int RC0_LSB  = 12;
  localparam int RC1_LSB  = 16;
  localparam int KLMN_LSB = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/share_valid_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | share_valid_pipe : LAT-deep {valid, index} shift register that mirrors   |
// | the S-box stage latency so captures land on the issued nibble. Rev 1.0   |
// +--------------------------------------------------------------------------+
module share_valid_pipe #(
  parameter int LAT   = 1,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid_i,
  input  logic [IDX_W-1:0] push_idx_i,
  output logic             head_valid_o,
  output logic [IDX_W-1:0] head_idx_o
);

  logic [LAT-1:0]   valid_q;
  logic [IDX_W-1:0] idx_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
    end else begin
      valid_q[0] <= push_valid_i;
      idx_q[0]   <= push_idx_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign head_valid_o = valid_q[LAT-1];
  assign head_idx_o   = idx_q[LAT-1];

endmodule
`default_nettype wire

// File: rtl/masked_nibble_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | masked_nibble_sequencer : streams a 3-share 64-bit state nibble by       |
// | nibble through a masked S-box stage and writes results back. Rev 1.0    |
// +--------------------------------------------------------------------------+
module masked_nibble_sequencer
  import skinny_mask_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in1,
  input  logic [STATE_W-1:0] state_in2,
  input  logic [STATE_W-1:0] state_in3,
  input  logic [RND_W-1:0]   rnd,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  output logic [3:0]         sb_in1,
  output logic [3:0]         sb_in2,
  output logic [3:0]         sb_in3,
  output logic [11:0]        sb_r,
  output logic [3:0]         sb_rc0,
  output logic [3:0]         sb_rc1,
  output logic [3:0]         sb_klmn,
  input  logic [3:0]         sb_out1,
  input  logic [3:0]         sb_out2,
  input  logic [3:0]         sb_out3,
  output logic [STATE_W-1:0] state_out1,
  output logic [STATE_W-1:0] state_out2,
  output logic [STATE_W-1:0] state_out3,
  output logic               busy,
  output logic               done
);

  seq_state_e         state_q;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   cap_cnt_q, cap_cnt_d;
  logic [STATE_W-1:0] buf_q [3];
  logic [STATE_W-1:0] buf_d [3];
  logic [STATE_W-1:0] out_q [3];
  logic               busy_q, done_q;

  logic [STATE_W-1:0] state_in_w [3];
  logic [3:0]         sb_out_w [3];
  logic [3:0]         sb_in_w [3];
  logic               accept, issue_fire, cap_valid;
  logic [IDX_W-1:0]   issue_idx, cap_idx;

  assign state_in_w[0] = state_in1;
  assign state_in_w[1] = state_in2;
  assign state_in_w[2] = state_in3;
  assign sb_out_w[0]   = sb_out1;
  assign sb_out_w[1]   = sb_out2;
  assign sb_out_w[2]   = sb_out3;

  assign accept     = (state_q == ST_IDLE) && start;
  // Gated by rst so nothing is presented to the stage while a reset is pending
  assign rnd_ready  = !rst && (state_q == ST_RUN) && (issue_cnt_q < NIB_CNT);
  assign issue_fire = rnd_valid && rnd_ready;
  assign issue_idx  = issue_cnt_q[IDX_W-1:0];

  share_valid_pipe #(
    .LAT   (LAT),
    .IDX_W (IDX_W)
  ) u_pipe (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (issue_fire),
    .push_idx_i   (issue_idx),
    .head_valid_o (cap_valid),
    .head_idx_o   (cap_idx)
  );

  // Stage inputs are forced to zero whenever no word is consumed this cycle
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      sb_in_w[s] = issue_fire ? buf_q[s][{issue_idx, 2'b00} +: 4] : 4'h0;
    end
    sb_r    = issue_fire ? rnd[R_LSB    +: 12] : 12'h0;
    sb_rc0  = issue_fire ? rnd[RC0_LSB  +: 4]  : 4'h0;
    sb_rc1  = issue_fire ? rnd[RC1_LSB  +: 4]  : 4'h0;
    sb_klmn = issue_fire ? rnd[KLMN_LSB +: 4]  : 4'h0;
  end

  assign sb_in1 = sb_in_w[0];
  assign sb_in2 = sb_in_w[1];
  assign sb_in3 = sb_in_w[2];

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      buf_d[s] = buf_q[s];
      if (accept) begin
        buf_d[s] = state_in_w[s];
      end else if (cap_valid) begin
        buf_d[s][{cap_idx, 2'b00} +: 4] = sb_out_w[s];
      end
    end
    issue_cnt_d = accept ? '0 : issue_cnt_q + CNT_W'(issue_fire);
    cap_cnt_d   = accept ? '0 : cap_cnt_q + CNT_W'(cap_valid);
  end

  // Transitions look at next-state counts so done lands right after the last capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      for (int s = 0; s < 3; s++) begin
        buf_q[s] <= '0;
        out_q[s] <= '0;
      end
    end else begin
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      for (int s = 0; s < 3; s++) buf_q[s] <= buf_d[s];
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (issue_cnt_d == NIB_CNT) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (cap_cnt_d == NIB_CNT) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            for (int s = 0; s < 3; s++) out_q[s] <= buf_d[s];
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state_out1 = out_q[0];
  assign state_out2 = out_q[1];
  assign state_out3 = out_q[2];
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire
